flex_stp_rcvr: RTL and testbench
================================

Name: flex_stp_rcvr

Overview:
Flexible serial-to-parallel receiver. It is the receive-side counterpart of the team's parallel-to-serial transmit shift register.
- Samples one serial bit per shift_enable strobe and assembles NUM_BITS-wide words.
- Hands each completed word to downstream logic through a one-word holding register with a valid/ready handshake.
- Flags overruns when downstream does not consume a word in time.

Parameters:
NUM_BITS, 8, data word width in bits; legal range 2 to 32.
SHIFT_MSB, 1, 1 = first received bit lands in data_out[NUM_BITS-1] (MSB-first line); 0 = first received bit lands in data_out[0] (LSB-first line).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous reset, active-high.
serial_in  input  1  serial data; idle level 1.
shift_enable  input  1  sample serial_in on this clock edge.
frame_clear  input  1  synchronous abort of the word in progress.
data_ready  input  1  downstream accepts data_out on this edge if data_valid=1.
ovr_clear  input  1  synchronous clear of the overrun flag.
data_out  output  NUM_BITS  last completed word (holding register).
data_valid  output  1  data_out holds an unconsumed word.
overrun  output  1  sticky: a completed word was dropped.
bit_count  output  $clog2(NUM_BITS+1)  bits received in the current word, 0..NUM_BITS-1.
parity_error  output  1  see Optional Feature.

Behaviour:
- Reset (async, immediate on rst=1): shift register all ones; bit_count=0; data_out all ones; data_valid=0; overrun=0; parity_error=0.
- Shift register and sampling:
  - SHIFT_MSB=1: sr <= {sr[NUM_BITS-2:0], serial_in}.
  - SHIFT_MSB=0: sr <= {serial_in, sr[NUM_BITS-1:1]}.
  - Updates only on edges where shift_enable=1 and frame_clear=0.
  - bit_count increments on every accepted sample.
- Word completion: a sample accepted while bit_count=NUM_BITS-1 completes the word.
  - bit_count wraps to 0 on that edge.
  - The completed word, including that final bit, is transferred to the holding register on the same edge.
  - data_out and data_valid therefore reflect it immediately after the edge; latency is 0 cycles after the final sample edge.
  - The shift register resets to all ones on completion.
- Holding FSM, two states:
  - EMPTY (data_valid=0): on completion, load data_out and go to FULL.
  - FULL (data_valid=1), acted on at each edge:
    - data_ready=1 and no completion: go to EMPTY; data_out holds its value.
    - data_ready=1 with completion on the same edge: load the new word and stay FULL. No overrun.
    - data_ready=0 with completion: new word is discarded, data_out unchanged, overrun <= 1.
- data_ready while EMPTY is ignored.
- frame_clear=1:
  - bit_count <= 0, shift register <= all ones. Any simultaneous shift_enable sample is dropped.
  - Holding register, data_valid and overrun are unaffected.
- overrun is sticky until ovr_clear=1 or rst.
  - If ovr_clear and a new overrun event occur on the same edge, overrun remains 1 (set wins).
- rst asserted mid-word discards the partial word and any held word.

Optional Feature:
Macro STP_RCVR_PARITY_EN.
- Defined:
  - After the NUM_BITS data bits, one further shift_enable sample is taken as an even-parity bit. bit_count counts 0..NUM_BITS.
  - Word completion and handoff occur on the parity-sample edge.
  - parity_error <= (^word) ^ parity_bit and is loaded together with data_out. It is valid while data_valid=1, and cleared to 0 when the word is consumed with no replacement.
  - A discarded (overrun) word does not update parity_error.
- Not defined: no parity bit is expected and parity_error is tied to 0.

Test Plan:
- NUM_BITS=8, SHIFT_MSB=1: shift in 1,0,1,0,0,1,0,1 on consecutive cycles -> data_out=8'hA5 and data_valid=1 right after the 8th edge, bit_count=0; data_ready=1 on the next edge -> data_valid=0, data_out stays 8'hA5.
- SHIFT_MSB=0: same bit stream -> data_out=8'hA5. The stream is a palindrome, so a second stream 1,1,0,0,0,0,0,0 is required -> data_out=8'h03.
- Receive 8'h3C, hold data_ready=0, receive 8'hFF -> data_out=8'h3C, overrun=1; assert ovr_clear for one cycle -> overrun=0, data_valid still 1.
- Word 8'h11 pending; data_ready=1 on the same edge that completes 8'h22 -> data_out=8'h22, data_valid=1, overrun=0.
- After 5 bits assert frame_clear together with shift_enable -> bit_count=0; the next 8 bits 0x0F produce data_out=8'h0F. Asserting rst mid-word -> all outputs at reset values immediately, no clock required.
- With STP_RCVR_PARITY_EN: send 8'hA5 followed by parity 0 -> parity_error=0; send 8'hA5 followed by parity 1 -> parity_error=1, data_out=8'hA5.

Source files
------------

// File: rtl/flex_stp_rcvr.sv
// flex_stp_rcvr: flexible serial-to-parallel receiver.
// Assembles NUM_BITS-wide words from one serial sample per shift_enable strobe,
// hands completed words downstream via a one-word holding register with a
// valid/ready handshake, and raises a sticky overrun flag on dropped words.
// Optional feature macro: STP_RCVR_PARITY_EN (trailing even-parity bit per word).
module flex_stp_rcvr #(
  parameter int unsigned NUM_BITS  = 8,
  parameter bit          SHIFT_MSB = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  input  logic                          shift_enable,
  input  logic                          frame_clear,
  input  logic                          data_ready,
  input  logic                          ovr_clear,
  output logic [NUM_BITS-1:0]           data_out,
  output logic                          data_valid,
  output logic                          overrun,
  output logic [$clog2(NUM_BITS+1)-1:0] bit_count,
  output logic                          parity_error
);

  localparam int unsigned CW = $clog2(NUM_BITS + 1);
`ifdef STP_RCVR_PARITY_EN
  localparam int unsigned LAST = NUM_BITS;
`else
  localparam int unsigned LAST = NUM_BITS - 1;
`endif

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [NUM_BITS-1:0] r_sr;
  logic [CW-1:0]       r_cnt;
  logic [NUM_BITS-1:0] r_data;
  logic                r_ovr;
  logic [NUM_BITS-1:0] w_sr_shift;
  logic [NUM_BITS-1:0] w_word;
  logic                w_accept;
  logic                w_last;
  logic                w_done;
  logic                w_load;
  logic                w_ovr_set;

  assign w_accept = shift_enable & ~frame_clear;
  assign w_last   = (r_cnt == CW'(LAST));
  assign w_done   = w_accept & w_last;

  // Shift register contents after taking the current serial sample.
  always_comb begin
    w_sr_shift = r_sr;
    if (SHIFT_MSB) w_sr_shift = {r_sr[NUM_BITS-2:0], serial_in};
    else           w_sr_shift = {serial_in, r_sr[NUM_BITS-1:1]};
  end

`ifdef STP_RCVR_PARITY_EN
  // Completion happens on the parity sample, so the word is already in r_sr.
  logic w_par_err;
  assign w_word    = r_sr;
  assign w_par_err = (^r_sr) ^ serial_in;
`else
  // Final data bit completes the word, so hand off the post-shift value.
  assign w_word = w_sr_shift;
`endif

  // Sample serial data and track position within the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sr  <= '1;
      r_cnt <= '0;
    end else if (frame_clear) begin
      r_sr  <= '1;
      r_cnt <= '0;
    end else if (shift_enable) begin
      if (w_last) begin
        r_sr  <= '1;
        r_cnt <= '0;
      end else begin
        r_sr  <= w_sr_shift;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Holding FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_nxt;
  end

  // Holding FSM next-state, load and overrun decisions.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_ovr_set   = 1'b0;
    unique case (r_state)
      EMPTY: begin
        if (w_done) begin
          w_load      = 1'b1;
          w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (data_ready) begin
          if (w_done) w_load      = 1'b1;
          else        w_state_nxt = EMPTY;
        end else if (w_done) begin
          w_ovr_set = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  // Holding register for the last accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_data <= '1;
    else if (w_load) r_data <= w_word;
  end

  // Sticky overrun flag; a new overrun wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovr <= 1'b0;
    else     r_ovr <= w_ovr_set | (r_ovr & ~ovr_clear);
  end

`ifdef STP_RCVR_PARITY_EN
  logic r_perr;
  // Parity status travels with the held word and clears when it is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    r_perr <= 1'b0;
    else if (w_load)                            r_perr <= w_par_err;
    else if ((r_state == FULL) && data_ready)   r_perr <= 1'b0;
  end
  assign parity_error = r_perr;
`else
  assign parity_error = 1'b0;
`endif

  assign data_out   = r_data;
  assign data_valid = (r_state == FULL);
  assign overrun    = r_ovr;
  assign bit_count  = r_cnt;

endmodule

// File: tb/tb_flex_stp_rcvr.sv
// Testbench for flex_stp_rcvr: one MSB-first and one LSB-first instance share
// the same stimulus. Honors STP_RCVR_PARITY_EN when defined.
module tb_flex_stp_rcvr;

  localparam int unsigned NB = 8;
  localparam int unsigned CW = $clog2(NB + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic serial_in = 1'b1;
  logic shift_enable = 1'b0;
  logic frame_clear = 1'b0;
  logic data_ready = 1'b0;
  logic ovr_clear = 1'b0;

  logic [NB-1:0] m_data, l_data;
  logic          m_valid, l_valid, m_ovr, l_ovr, m_perr, l_perr;
  logic [CW-1:0] m_cnt, l_cnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  flex_stp_rcvr #(.NUM_BITS(NB), .SHIFT_MSB(1'b1)) u_msb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_enable(shift_enable),
    .frame_clear(frame_clear), .data_ready(data_ready), .ovr_clear(ovr_clear),
    .data_out(m_data), .data_valid(m_valid), .overrun(m_ovr),
    .bit_count(m_cnt), .parity_error(m_perr)
  );

  flex_stp_rcvr #(.NUM_BITS(NB), .SHIFT_MSB(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .serial_in(serial_in), .shift_enable(shift_enable),
    .frame_clear(frame_clear), .data_ready(data_ready), .ovr_clear(ovr_clear),
    .data_out(l_data), .data_valid(l_valid), .overrun(l_ovr),
    .bit_count(l_cnt), .parity_error(l_perr)
  );

  // One accepted sample; returns #1 after the sampling edge.
  task automatic send_bit(input logic b);
    serial_in = b;
    shift_enable = 1'b1;
    @(posedge clk); #1;
    shift_enable = 1'b0;
    serial_in = 1'b1;
  endtask

  // Sends w MSB-first (plus parity when enabled); optional ovr_clear/data_ready
  // asserted only on the completing edge.
  task automatic send_word(input logic [NB-1:0] w, input logic par_flip,
                           input logic ovr_last, input logic rdy_last);
    for (int i = NB - 1; i >= 0; i--) begin
`ifndef STP_RCVR_PARITY_EN
      if (i == 0) begin
        ovr_clear = ovr_last;
        data_ready = rdy_last;
      end
`endif
      send_bit(w[i]);
    end
`ifdef STP_RCVR_PARITY_EN
    ovr_clear = ovr_last;
    data_ready = rdy_last;
    send_bit((^w) ^ par_flip);
`endif
    ovr_clear = 1'b0;
    data_ready = 1'b0;
  endtask

  task automatic consume();
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    n_total++; if (m_data !== 8'hFF) $display("FAIL reset_data got %h want ff", m_data); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", m_valid); else n_pass++;
    n_total++; if (m_ovr !== 1'b0) $display("FAIL reset_ovr got %b want 0", m_ovr); else n_pass++;
    n_total++; if (m_cnt !== '0) $display("FAIL reset_cnt got %0d want 0", m_cnt); else n_pass++;
    n_total++; if (m_perr !== 1'b0) $display("FAIL reset_perr got %b want 0", m_perr); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_msb_first();
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    n_total++; if (m_data !== 8'hA5) $display("FAIL msb_data got %h want a5", m_data); else n_pass++;
    n_total++; if (m_valid !== 1'b1) $display("FAIL msb_valid got %b want 1", m_valid); else n_pass++;
    n_total++; if (m_cnt !== '0) $display("FAIL msb_cnt got %0d want 0", m_cnt); else n_pass++;
    n_total++; if (l_data !== 8'hA5) $display("FAIL lsb_pal_data got %h want a5", l_data); else n_pass++;
    consume();
    n_total++; if (m_valid !== 1'b0) $display("FAIL consume_valid got %b want 0", m_valid); else n_pass++;
    n_total++; if (m_data !== 8'hA5) $display("FAIL consume_hold got %h want a5", m_data); else n_pass++;
    consume();
    n_total++; if (m_valid !== 1'b0) $display("FAIL ready_empty got %b want 0", m_valid); else n_pass++;
  endtask

  task automatic test_lsb_first();
    // Stream 1,1,0,0,0,0,0,0
    send_word(8'hC0, 1'b0, 1'b0, 1'b0);
    n_total++; if (l_data !== 8'h03) $display("FAIL lsb_data got %h want 03", l_data); else n_pass++;
    n_total++; if (m_data !== 8'hC0) $display("FAIL msb_c0_data got %h want c0", m_data); else n_pass++;
    consume();
  endtask

  task automatic test_overrun();
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    n_total++; if (m_data !== 8'h3C) $display("FAIL ovr_data got %h want 3c", m_data); else n_pass++;
    n_total++; if (m_ovr !== 1'b1) $display("FAIL ovr_flag got %b want 1", m_ovr); else n_pass++;
    ovr_clear = 1'b1;
    @(posedge clk); #1;
    ovr_clear = 1'b0;
    n_total++; if (m_ovr !== 1'b0) $display("FAIL ovr_clear got %b want 0", m_ovr); else n_pass++;
    n_total++; if (m_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", m_valid); else n_pass++;
    // New overrun on the same edge as ovr_clear: set wins.
    send_word(8'h55, 1'b0, 1'b1, 1'b0);
    n_total++; if (m_ovr !== 1'b1) $display("FAIL ovr_setwins got %b want 1", m_ovr); else n_pass++;
    n_total++; if (m_data !== 8'h3C) $display("FAIL ovr_keep got %h want 3c", m_data); else n_pass++;
    ovr_clear = 1'b1;
    @(posedge clk); #1;
    ovr_clear = 1'b0;
    consume();
  endtask

  task automatic test_back_to_back();
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b1);
    n_total++; if (m_data !== 8'h22) $display("FAIL b2b_data got %h want 22", m_data); else n_pass++;
    n_total++; if (m_valid !== 1'b1) $display("FAIL b2b_valid got %b want 1", m_valid); else n_pass++;
    n_total++; if (m_ovr !== 1'b0) $display("FAIL b2b_ovr got %b want 0", m_ovr); else n_pass++;
    consume();
  endtask

  task automatic test_frame_clear();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    n_total++; if (m_cnt !== CW'(5)) $display("FAIL fc_cnt5 got %0d want 5", m_cnt); else n_pass++;
    frame_clear = 1'b1;
    serial_in = 1'b0;
    shift_enable = 1'b1;
    @(posedge clk); #1;
    frame_clear = 1'b0;
    shift_enable = 1'b0;
    serial_in = 1'b1;
    n_total++; if (m_cnt !== '0) $display("FAIL fc_cnt got %0d want 0", m_cnt); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL fc_valid got %b want 0", m_valid); else n_pass++;
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    n_total++; if (m_data !== 8'h0F) $display("FAIL fc_data got %h want 0f", m_data); else n_pass++;
    // Leave 8'h0F held, start a partial word, then reset asynchronously.
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    #2;
    rst = 1'b1;
    #1;
    n_total++; if (m_data !== 8'hFF) $display("FAIL arst_data got %h want ff", m_data); else n_pass++;
    n_total++; if (m_valid !== 1'b0) $display("FAIL arst_valid got %b want 0", m_valid); else n_pass++;
    n_total++; if (m_cnt !== '0) $display("FAIL arst_cnt got %0d want 0", m_cnt); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef STP_RCVR_PARITY_EN
  task automatic test_parity();
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    n_total++; if (m_perr !== 1'b0) $display("FAIL par_ok got %b want 0", m_perr); else n_pass++;
    n_total++; if (m_data !== 8'hA5) $display("FAIL par_ok_data got %h want a5", m_data); else n_pass++;
    consume();
    send_word(8'hA5, 1'b1, 1'b0, 1'b0);
    n_total++; if (m_perr !== 1'b1) $display("FAIL par_err got %b want 1", m_perr); else n_pass++;
    n_total++; if (m_data !== 8'hA5) $display("FAIL par_err_data got %h want a5", m_data); else n_pass++;
    consume();
    n_total++; if (m_perr !== 1'b0) $display("FAIL par_consumed got %b want 0", m_perr); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_overrun();
    test_back_to_back();
    test_frame_clear();
`ifdef STP_RCVR_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
